// File: rtl/op_sequencer_if.sv
// Op word definition and the host/cpu-facing bundle of the op sequencer.
// The sequencer takes the master modport; the host/loader and cpu stub take the slave modport.
package op_sequencer_pkg;

    typedef enum logic [2:0] {
        NO_OP     = 3'd0,
        CT_CT_ADD = 3'd1,
        CT_PT_ADD = 3'd2,
        CT_PT_MUL = 3'd3,
        CT_CT_MUL = 3'd4
    } op_mode_e;

    typedef struct packed {
        op_mode_e   mode;
        logic [3:0] src0;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] src3;
        logic [3:0] dst0;
        logic [3:0] dst1;
    } operation;

endpackage

interface op_sequencer_if
    import op_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 16
);
    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

    logic          prog_we;
    logic [AW-1:0] prog_waddr;
    operation      prog_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    operation      op;
    logic          done_in;
    logic          busy;
    logic          seq_done;
    logic          error;
    logic [AW-1:0] pc;
    logic [AW:0]   issued_count;

    modport master (
        input  prog_we, prog_waddr, prog_wdata, prog_len, start, done_in,
        output op, busy, seq_done, error, pc, issued_count
    );

    modport slave (
        output prog_we, prog_waddr, prog_wdata, prog_len, start, done_in,
        input  op, busy, seq_done, error, pc, issued_count
    );

endinterface

// File: rtl/op_sequencer.sv
// Program-driven op issuer: walks a preloaded program, pulses each op for one cycle,
// waits for done with a per-op timeout, and inserts one writeback-settle cycle between ops.
//
// state  | meaning
// IDLE   | program writable, waiting for start
// ISSUE  | op valid at cpu this cycle only (skip slots issue nothing)
// WAIT   | counting cycles until done_in or timeout
// SETTLE | writeback settle; advance pc or finish
// FINISH | one-cycle seq_done pulse
// ERROR  | timeout seen; held until reset
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic          clk,
    input  logic          reset_n,
    op_sequencer_if.master bus
);

    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(PROG_DEPTH);
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SETTLE,
        S_FINISH,
        S_ERROR
    } state_e;

    state_e        state_q, state_d;
    operation      prog [PROG_DEPTH];
    operation      op_q, op_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issued_q, issued_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          prog_wr;
    logic [AW:0]   len_clamped;
    logic [AW-1:0] rd_addr;
    operation      rd_word;

    assign prog_wr     = bus.prog_we && (state_q == S_IDLE);
    assign len_clamped = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;

    // The op register is loaded on entry to ISSUE, so the slot is read one cycle early;
    // a write landing in the start cycle is forwarded so the run sees the new word.
    assign rd_addr = (state_q == S_SETTLE) ? pc_q + 1'b1 : '0;
    assign rd_word = (prog_wr && (bus.prog_waddr == rd_addr)) ? bus.prog_wdata : prog[rd_addr];

    always_ff @(posedge clk) begin
        if (prog_wr) begin
            prog[bus.prog_waddr] <= bus.prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            pc_q     <= '0;
            len_q    <= '0;
            issued_q <= '0;
            cnt_q    <= '0;
        end else begin
            op_q     <= op_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pc_d     = pc_q;
        len_d    = len_q;
        issued_d = issued_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d    = len_clamped;
                    pc_d     = '0;
                    issued_d = '0;
                    cnt_d    = '0;
                    if (len_clamped == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                        if (rd_word.mode != NO_OP) begin
                            op_d = rd_word;
                        end
                    end
                end
            end
            S_ISSUE: begin
                // op_q.mode is NO_OP here exactly when the slot is a skip slot
                if (op_q.mode != NO_OP) begin
                    op_d.mode = NO_OP;
                    issued_d  = issued_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_WAIT: begin
                if (bus.done_in) begin
                    state_d = S_SETTLE;
                end else if (cnt_q == TC_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if ({1'b0, pc_q} == (len_q - 1'b1)) begin
                    state_d = S_FINISH;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_ISSUE;
                    if (rd_word.mode != NO_OP) begin
                        op_d = rd_word;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.op           = op_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.seq_done     = (state_q == S_FINISH);
    assign bus.error        = (state_q == S_ERROR);
    assign bus.pc           = pc_q;
    assign bus.issued_count = issued_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: fixed scenario table, hand-written reset/forwarding sequences,
// and randomized programs checked against a timeline model of the issue schedule.
module tb_op_sequencer;
    import op_sequencer_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    op_sequencer_if #(.PROG_DEPTH(DEPTH)) bus ();

    op_sequencer #(.PROG_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    operation prog_m [DEPTH];
    int lat  [DEPTH];
    int hold [DEPTH];
    bit noise_en = 1'b0;

    int       got_iss_cyc[$];
    operation got_iss_word[$];
    int got_done_cyc, got_done_cnt, got_err_cyc, got_idle_cyc, got_pc, got_cnt;

    int       exp_iss_cyc[$];
    operation exp_iss_word[$];
    int exp_done_cyc, exp_err_cyc, exp_pc, exp_cnt;

    typedef struct {
        int          len;
        int          lat;
        logic [15:0] skip;
        int          iss0;
        int          iss1;
        int          n_iss;
        int          done_cyc;
        int          err_cyc;
        int          pc;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic operation rand_op(input bit allow_skip);
        logic [31:0] r;
        operation w;
        r = $urandom;
        w = operation'(r[$bits(operation)-1:0]);
        w.mode = op_mode_e'($urandom_range(allow_skip ? 0 : 1, 4));
        return w;
    endfunction

    function automatic operation mk(input op_mode_e m, input int a, input int b, input int c,
                                    input int d, input int e, input int f);
        operation w;
        w.mode = m;
        w.src0 = 4'(a); w.src1 = 4'(b); w.src2 = 4'(c); w.src3 = 4'(d);
        w.dst0 = 4'(e); w.dst1 = 4'(f);
        return w;
    endfunction

    task automatic write_slot(input int a, input operation w);
        bus.prog_we    = 1'b1;
        bus.prog_waddr = AW'(a);
        bus.prog_wdata = w;
        @(posedge clk); #1;
        bus.prog_we = 1'b0;
        prog_m[a] = w;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_op"},       longint'(bus.op), 0);
        chk({tag, "_busy"},     bus.busy, 0);
        chk({tag, "_seq_done"}, bus.seq_done, 0);
        chk({tag, "_error"},    bus.error, 0);
        chk({tag, "_pc"},       bus.pc, 0);
        chk({tag, "_issued"},   bus.issued_count, 0);
    endtask

    task automatic reset_pulse(input string tag);
        bus.done_in = 1'b0;
        reset_n = 1'b0;
        #1 check_reset(tag);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Timeline of a run: an issued op occupies ISSUE + latency + SETTLE, a skip slot
    // occupies ISSUE + SETTLE, and the first FINISH cycle follows the last settle.
    task automatic model(input int len_in);
        int n;
        int t;
        int k;
        n = (len_in > DEPTH) ? DEPTH : len_in;
        t = 1;
        k = 0;
        exp_iss_cyc.delete();
        exp_iss_word.delete();
        exp_done_cyc = 0; exp_err_cyc = 0; exp_pc = 0; exp_cnt = 0;
        for (int i = 0; i < n; i++) begin
            exp_pc = i;
            if (prog_m[i].mode == NO_OP) begin
                t += 2;
            end else begin
                exp_iss_cyc.push_back(t);
                exp_iss_word.push_back(prog_m[i]);
                exp_cnt++;
                if (lat[k] > TO) begin
                    exp_err_cyc = t + TO + 1;
                    return;
                end
                t += lat[k] + 2;
                k++;
            end
        end
        exp_done_cyc = t;
    endtask

    task automatic run(input int len_in);
        int c;
        int k;
        int done_at;
        int hold_end;
        bit fin;
        bit d;
        c = 0; k = 0; done_at = -1; hold_end = -1; fin = 1'b0;
        got_iss_cyc.delete();
        got_iss_word.delete();
        got_done_cyc = 0; got_done_cnt = 0; got_err_cyc = 0; got_idle_cyc = 0;
        got_pc = -1; got_cnt = -1;
        bus.prog_len = (AW + 1)'(len_in);
        bus.start = 1'b1;
        while (!fin && c < 600) begin
            @(posedge clk); #1;
            c++;
            bus.start   = 1'b0;
            bus.prog_we = 1'b0;
            d = (c >= done_at) && (c <= hold_end);
            if (bus.op.mode != NO_OP) begin
                got_iss_cyc.push_back(c);
                got_iss_word.push_back(bus.op);
                if (k < DEPTH) begin
                    done_at  = c + lat[k];
                    hold_end = done_at + hold[k] - 1;
                end
                k++;
            end
            bus.done_in = d;
            if (bus.seq_done) begin
                got_done_cnt++;
                if (got_done_cyc == 0) got_done_cyc = c;
            end
            if (bus.error && got_err_cyc == 0) begin
                got_err_cyc = c;
                got_pc  = bus.pc;
                got_cnt = bus.issued_count;
                bus.start    = 1'b1;
                bus.prog_len = 5'd1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                chk("err_sticky", bus.error, 1);
                chk("err_busy", bus.busy, 1);
                chk("err_pc_frozen", bus.pc, exp_pc);
                fin = 1'b1;
            end else if (!bus.busy) begin
                got_idle_cyc = c;
                got_pc  = bus.pc;
                got_cnt = bus.issued_count;
                fin = 1'b1;
            end else if (noise_en) begin
                if ($urandom_range(0, 3) == 0) bus.start = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    bus.prog_we    = 1'b1;
                    bus.prog_waddr = AW'($urandom_range(0, DEPTH - 1));
                    bus.prog_wdata = rand_op(1'b1);
                end
            end
        end
        bus.done_in = 1'b0;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        if (!fin) chk("run_budget_expired", c, -1);
    endtask

    task automatic compare_model(input string tag);
        int n;
        chk({tag, "_n_issue"}, got_iss_cyc.size(), exp_iss_cyc.size());
        n = (got_iss_cyc.size() < exp_iss_cyc.size()) ? got_iss_cyc.size() : exp_iss_cyc.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_issue%0d_cycle", tag, i), got_iss_cyc[i], exp_iss_cyc[i]);
            chk($sformatf("%s_issue%0d_word", tag, i), longint'(got_iss_word[i]), longint'(exp_iss_word[i]));
        end
        chk({tag, "_done_cycle"}, got_done_cyc, exp_done_cyc);
        chk({tag, "_done_pulses"}, got_done_cnt, (exp_err_cyc == 0) ? 1 : 0);
        chk({tag, "_err_cycle"}, got_err_cyc, exp_err_cyc);
        chk({tag, "_idle_cycle"}, got_idle_cyc, (exp_err_cyc == 0) ? exp_done_cyc + 1 : 0);
        chk({tag, "_pc"}, got_pc, exp_pc);
        chk({tag, "_issued_count"}, got_cnt, exp_cnt);
    endtask

    initial begin
        //            len lat skip      iss0 iss1 n  done err pc
        tbl[0] = '{3,  2, 16'h0000, 1,   5,   3, 13,  0,  2};
        tbl[1] = '{2,  4, 16'h0000, 1,   7,   2, 13,  0,  1};
        tbl[2] = '{3,  4, 16'h0002, 1,   9,   2, 15,  0,  2};
        tbl[3] = '{0,  4, 16'h0000, 0,   0,   0,  1,  0,  0};
        tbl[4] = '{1,  8, 16'h0000, 1,   0,   1, 11,  0,  0};
        tbl[5] = '{1,  9, 16'h0000, 1,   0,   1,  0, 10,  0};
        tbl[6] = '{20, 1, 16'h0000, 1,   4,  16, 49,  0, 15};
        tbl[7] = '{2,  8, 16'h0001, 3,   0,   1, 13,  0,  1};

        bus.prog_we = 1'b0; bus.prog_waddr = '0; bus.prog_wdata = '0;
        bus.prog_len = '0; bus.start = 1'b0; bus.done_in = 1'b0;

        repeat (2) @(posedge clk);
        #1 check_reset("por");
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            for (int s = 0; s < DEPTH; s++) begin
                operation w;
                w = rand_op(1'b0);
                if (tbl[v].skip[s]) w.mode = NO_OP;
                if (v == 0 && s == 0) w = mk(CT_CT_ADD, 0, 1, 2, 3, 5, 6);
                if (v == 0 && s == 1) w = mk(CT_PT_ADD, 0, 1, 0, 4, 7, 8);
                if (v == 0 && s == 2) w = mk(CT_PT_MUL, 0, 1, 0, 4, 9, 10);
                write_slot(s, w);
            end
            for (int s = 0; s < DEPTH; s++) begin
                lat[s]  = tbl[v].lat;
                hold[s] = 1;
            end
            model(tbl[v].len);
            run(tbl[v].len);
            chk($sformatf("tbl%0d_n_issue", v), got_iss_cyc.size(), tbl[v].n_iss);
            chk($sformatf("tbl%0d_issue0", v), (got_iss_cyc.size() > 0) ? got_iss_cyc[0] : 0, tbl[v].iss0);
            chk($sformatf("tbl%0d_issue1", v), (got_iss_cyc.size() > 1) ? got_iss_cyc[1] : 0, tbl[v].iss1);
            chk($sformatf("tbl%0d_done", v), got_done_cyc, tbl[v].done_cyc);
            chk($sformatf("tbl%0d_err", v), got_err_cyc, tbl[v].err_cyc);
            chk($sformatf("tbl%0d_pc", v), got_pc, tbl[v].pc);
            chk($sformatf("tbl%0d_issued", v), got_cnt, tbl[v].n_iss);
            compare_model($sformatf("tbl%0d", v));
            if (tbl[v].err_cyc != 0) reset_pulse($sformatf("tbl%0d_reset", v));
        end

        // Asynchronous reset in the middle of WAIT, then a rerun proves memory survived.
        for (int s = 0; s < DEPTH; s++) begin
            write_slot(s, rand_op(1'b0));
            lat[s] = 5;
            hold[s] = 2;
        end
        bus.prog_len = 5'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("midwait_issue_word", longint'(bus.op), longint'(prog_m[0]));
        @(posedge clk); #1;
        chk("midwait_op_mode", bus.op.mode, NO_OP);
        chk("midwait_op_hold", bus.op.dst1, prog_m[0].dst1);
        chk("midwait_busy", bus.busy, 1);
        #2 reset_n = 1'b0;
        #1 check_reset("midwait_async");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        model(4);
        run(4);
        compare_model("after_reset");

        // Write and start in the same IDLE cycle: the run must issue the new slot-0 word.
        begin
            operation w;
            w = rand_op(1'b0);
            bus.prog_we    = 1'b1;
            bus.prog_waddr = '0;
            bus.prog_wdata = w;
            prog_m[0] = w;
        end
        model(2);
        run(2);
        compare_model("we_with_start");

        noise_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int len;
            for (int s = 0; s < DEPTH; s++) begin
                write_slot(s, rand_op($urandom_range(0, 3) == 0));
                lat[s]  = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(1, TO);
                hold[s] = $urandom_range(1, 3);
            end
            len = $urandom_range(0, DEPTH + 4);
            model(len);
            run(len);
            compare_model($sformatf("rnd%0d", it));
            if (exp_err_cyc != 0) reset_pulse($sformatf("rnd%0d_reset", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
